// File: rtl/video_capture_if.sv
// video_capture_if: raw pixel/sync input bus and aligned capture output bus.
interface video_capture_if;
  logic        pe_i;
  logic [15:0] DATA_in;
  logic        HSYNC_in;
  logic        VSYNC_in;
  logic [15:0] DATA_o;
  logic        DE_o;
  logic        HSYNC_o;
  logic        VSYNC_o;
  logic [8:0]  xpos_o;
  logic [8:0]  ypos_o;
  logic        FID_o;
  logic        frame_change_o;
  logic [10:0] h_total_o;
  logic [9:0]  v_total_o;
  logic        locked_o;
  modport master (
    output pe_i, DATA_in, HSYNC_in, VSYNC_in,
    input  DATA_o, DE_o, HSYNC_o, VSYNC_o, xpos_o, ypos_o, FID_o, frame_change_o,
           h_total_o, v_total_o, locked_o
  );
  modport slave (
    input  pe_i, DATA_in, HSYNC_in, VSYNC_in,
    output DATA_o, DE_o, HSYNC_o, VSYNC_o, xpos_o, ypos_o, FID_o, frame_change_o,
           h_total_o, v_total_o, locked_o
  );
endinterface

// File: rtl/video_capture.sv
// video_capture: measures line/frame timing of a pe-qualified pixel bus and emits an aligned active-area stream.
module video_capture #(
  parameter int H_ACTIVE    = 384,
  parameter int V_ACTIVE    = 224,
  parameter int H_START     = 64,
  parameter int V_START     = 16,
  parameter int LOCK_FRAMES = 4
) (
  input logic            PCLK_i,
  input logic            reset_i,
  video_capture_if.slave bus
);
  typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} state_t;
  localparam int LW = $clog2(LOCK_FRAMES + 1);
  localparam logic [10:0]   HS0 = 11'(H_START);
  localparam logic [10:0]   HS1 = 11'(H_START + H_ACTIVE);
  localparam logic [9:0]    VS0 = 10'(V_START);
  localparam logic [9:0]    VS1 = 10'(V_START + V_ACTIVE);
  localparam logic [9:0]    VFC = 10'(V_START + 2);
  localparam logic [LW-1:0] LF  = LW'(LOCK_FRAMES);
  state_t        r_state, w_state_n;
  logic [LW-1:0] r_lcnt, w_lcnt_n;
  logic [10:0]   r_h_cnt, r_h_tot, w_h_inc, w_h_cnt_n, w_h_tot_n;
  logic [9:0]    r_v_cnt, r_v_tot, w_v_inc, w_v_cnt_n, w_v_tot_n;
  logic [15:0]   r_data;
  logic          r_hs, r_vs, r_pend, r_fid, r_fc, r_pe;
  logic          w_hfall, w_vfall, w_pend, w_fe, w_bad, w_fid_n, w_fc_n, w_act;
  assign w_hfall   = !bus.HSYNC_in && r_hs;
  assign w_vfall   = !bus.VSYNC_in && r_vs;
  assign w_pend    = r_pend || w_vfall;
  assign w_fe      = w_hfall && w_pend;
  assign w_h_inc   = r_h_cnt + 11'(r_h_cnt != '1);
  assign w_v_inc   = r_v_cnt + 10'(r_v_cnt != '1);
  assign w_h_cnt_n = w_hfall ? '0 : w_h_inc;
  assign w_h_tot_n = w_hfall ? w_h_inc : r_h_tot;
  assign w_v_cnt_n = w_fe ? '0 : w_hfall ? w_v_inc : r_v_cnt;
  assign w_v_tot_n = w_fe ? w_v_inc : r_v_tot;
  assign w_fid_n   = w_vfall ? (w_h_cnt_n >= (w_h_tot_n >> 1)) : r_fid;
  assign w_fc_n    = (w_hfall && w_v_cnt_n == VS0) ? 1'b1 : (w_hfall && w_v_cnt_n == VFC) ? 1'b0 : r_fc;
  // Any timing disagreement or a line with no HSYNC drops lock immediately
  assign w_bad     = (w_hfall && w_h_tot_n != r_h_tot) || (w_fe && w_v_tot_n != r_v_tot) || w_h_cnt_n == '1;
  assign w_act     = r_pe && r_state == LOCKED && r_h_cnt >= HS0 && r_h_cnt < HS1 && r_v_cnt >= VS0 && r_v_cnt < VS1;
  always_comb begin
    w_state_n = r_state;
    w_lcnt_n  = r_lcnt;
    if (w_bad) begin
      w_state_n = UNLOCKED;
      w_lcnt_n  = '0;
    end else if (r_state == UNLOCKED && w_vfall) begin
      w_state_n = CHECK;
    end else if (r_state == CHECK && w_fe) begin
      w_lcnt_n  = r_lcnt + LW'(1);
      w_state_n = (w_lcnt_n == LF) ? LOCKED : CHECK;
    end
  end
  always_ff @(posedge PCLK_i) begin
    if (reset_i) begin
      r_state <= UNLOCKED;
      r_lcnt  <= '0;
      r_h_cnt <= '0;
      r_h_tot <= '0;
      r_v_cnt <= '0;
      r_v_tot <= '0;
      r_data  <= '0;
      r_hs    <= 1'b1;
      r_vs    <= 1'b1;
      r_pend  <= 1'b0;
      r_fid   <= 1'b0;
      r_fc    <= 1'b0;
      r_pe    <= 1'b0;
    end else begin
      r_pe <= bus.pe_i;
      if (bus.pe_i) begin
        r_state <= w_state_n;
        r_lcnt  <= w_lcnt_n;
        r_h_cnt <= w_h_cnt_n;
        r_h_tot <= w_h_tot_n;
        r_v_cnt <= w_v_cnt_n;
        r_v_tot <= w_v_tot_n;
        r_data  <= bus.DATA_in;
        r_hs    <= bus.HSYNC_in;
        r_vs    <= bus.VSYNC_in;
        r_pend  <= w_pend && !w_hfall;
        r_fid   <= w_fid_n;
        r_fc    <= w_fc_n;
      end
    end
  end
  always_ff @(posedge PCLK_i) begin
    if (reset_i) begin
      bus.DATA_o         <= '0;
      bus.DE_o           <= 1'b0;
      bus.HSYNC_o        <= 1'b1;
      bus.VSYNC_o        <= 1'b1;
      bus.xpos_o         <= '0;
      bus.ypos_o         <= '0;
      bus.FID_o          <= 1'b0;
      bus.frame_change_o <= 1'b0;
      bus.h_total_o      <= '0;
      bus.v_total_o      <= '0;
      bus.locked_o       <= 1'b0;
    end else begin
      bus.DE_o           <= w_act;
      bus.HSYNC_o        <= r_hs;
      bus.VSYNC_o        <= r_vs;
      bus.FID_o          <= r_fid;
      bus.frame_change_o <= r_fc;
      bus.h_total_o      <= r_h_tot;
      bus.v_total_o      <= r_v_tot;
      bus.locked_o       <= r_state == LOCKED;
      if (w_act) begin
        bus.DATA_o <= r_data;
        bus.xpos_o <= 9'(r_h_cnt - HS0);
        bus.ypos_o <= 9'(r_v_cnt - VS0);
      end else if (r_pe && r_v_cnt < VS0) begin
        bus.ypos_o <= '0;
      end
    end
  end
endmodule

// File: tb/tb_video_capture.sv
// tb_video_capture: directed frames against a sample-level timing model delayed to the output stage.
module tb_video_capture;
  localparam int HA = 8, VA = 4, HS = 4, VS = 2, LF = 4, HT = 16;
  typedef struct packed {
    logic [15:0] data;
    logic        de, hs, vs;
    logic [8:0]  x, y;
    logic        fid, fc;
    logic [10:0] ht;
    logic [9:0]  vt;
    logic        lk;
  } rec_t;
  logic clk = 1'b0;
  logic reset_i;
  video_capture_if b();
  video_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_START(HS), .V_START(VS), .LOCK_FRAMES(LF)) dut (
    .PCLK_i(clk), .reset_i(reset_i), .bus(b)
  );
  always #5 clk = ~clk;
  rec_t got, exp_r, pend_r, first_r;
  assign got = {b.DATA_o, b.DE_o, b.HSYNC_o, b.VSYNC_o, b.xpos_o, b.ypos_o, b.FID_o,
                b.frame_change_o, b.h_total_o, b.v_total_o, b.locked_o};
  int n_cmp = 0, n_bad = 0, de_cnt = 0, de_unlk = 0, consec = 0, c0;
  bit chk_en = 0, prev_de = 0, seen = 0;
  int m_hc, m_vc, m_ht, m_vt, m_n, m_lk;
  bit m_ph, m_pv, m_pend, m_fid, m_fc;
  function automatic rec_t rst_rec();
    rec_t r;
    r = '0;
    r.hs = 1'b1;
    r.vs = 1'b1;
    return r;
  endfunction
  task automatic step(input logic hs, input logic vs, input logic [15:0] d);
    bit hf, vf, fe, bad;
    int nt;
    hf = !hs && m_ph;
    vf = !vs && m_pv;
    m_ph = hs;
    m_pv = vs;
    bad = 0;
    fe = 0;
    if (vf) m_pend = 1;
    if (hf) begin
      nt = (m_hc + 1 > 2047) ? 2047 : m_hc + 1;
      bad = nt != m_ht;
      m_ht = nt;
      m_hc = 0;
      if (m_pend) begin
        fe = 1;
        nt = (m_vc + 1 > 1023) ? 1023 : m_vc + 1;
        if (nt != m_vt) bad = 1;
        m_vt = nt;
        m_vc = 0;
        m_pend = 0;
      end else m_vc = (m_vc < 1023) ? m_vc + 1 : 1023;
      if (m_vc == VS) m_fc = 1;
      if (m_vc == VS + 2) m_fc = 0;
    end else m_hc = (m_hc < 2047) ? m_hc + 1 : 2047;
    if (vf) m_fid = m_hc >= m_ht / 2;
    if (m_hc == 2047) bad = 1;
    if (bad) begin
      m_lk = 0;
      m_n = 0;
    end else if (m_lk == 0 && vf) m_lk = 1;
    else if (m_lk == 1 && fe) begin
      m_n = m_n + 1;
      if (m_n == LF) m_lk = 2;
    end
    pend_r.hs = hs;
    pend_r.vs = vs;
    pend_r.ht = 11'(m_ht);
    pend_r.vt = 10'(m_vt);
    pend_r.fid = m_fid;
    pend_r.fc = m_fc;
    pend_r.lk = m_lk == 2;
    pend_r.de = m_lk == 2 && m_hc >= HS && m_hc < HS + HA && m_vc >= VS && m_vc < VS + VA;
    if (pend_r.de) begin
      pend_r.data = d;
      pend_r.x = 9'(m_hc - HS);
      pend_r.y = 9'(m_vc - VS);
    end else if (m_vc < VS) pend_r.y = '0;
  endtask
  always @(posedge clk) begin
    if (reset_i) begin
      m_hc = 0; m_vc = 0; m_ht = 0; m_vt = 0; m_n = 0; m_lk = 0;
      m_ph = 1; m_pv = 1; m_pend = 0; m_fid = 0; m_fc = 0;
      exp_r = rst_rec();
      pend_r = rst_rec();
    end else begin
      exp_r = pend_r;
      if (b.pe_i) step(b.HSYNC_in, b.VSYNC_in, b.DATA_in);
      else pend_r.de = 1'b0;
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (got !== exp_r) begin
        n_bad++;
        $display("FAIL stream @%0t got=%h want=%h", $time, got, exp_r);
      end
      if (got.de) begin
        de_cnt++;
        if (!got.lk) de_unlk++;
        if (prev_de) consec++;
        if (!seen) begin
          seen = 1;
          first_r = got;
        end
      end
      prev_de = got.de;
    end
  end
  task automatic check(input string nm, input logic [63:0] g, input logic [63:0] w);
    n_cmp++;
    if (g !== w) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", nm, g, w);
    end
  endtask
  task automatic samp(input logic hs, input logic vs, input logic [15:0] d, input bit alt);
    @(negedge clk);
    b.pe_i = 1'b1;
    b.HSYNC_in = hs;
    b.VSYNC_in = vs;
    b.DATA_in = d;
    if (alt) begin
      @(negedge clk);
      b.pe_i = 1'b0;
      b.HSYNC_in = 1'b0;
      b.VSYNC_in = 1'b0;
      b.DATA_in = 16'hdead;
    end
  endtask
  task automatic frame(input int vt, input int voff, input bit alt, input bit rst_mid);
    int i;
    for (int l = 0; l < vt; l++) begin
      for (int p = 0; p < HT; p++) begin
        i = l * HT + p;
        if (rst_mid && l == 3 && p == 6) begin
          @(negedge clk);
          reset_i = 1'b1;
          b.pe_i = 1'b1;
          @(negedge clk);
          check("rst_mid", got, rst_rec());
          reset_i = 1'b0;
          b.pe_i = 1'b0;
        end else begin
          samp(p >= 3, !(i >= voff && i < voff + 3 * HT), {8'(l), 8'(p)}, alt);
        end
      end
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    b.pe_i = 1'b0;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
  endtask
  initial begin
    reset_i = 1'b1;
    b.pe_i = 1'b0;
    b.HSYNC_in = 1'b1;
    b.VSYNC_in = 1'b1;
    b.DATA_in = '0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("reset", got, rst_rec());
    reset_i = 1'b0;
    repeat (6) frame(10, 0, 0, 0);
    check("lock_after6", b.locked_o, 0);
    frame(10, 0, 0, 0);
    check("lock_after7", b.locked_o, 1);
    check("totals", {b.h_total_o, b.v_total_o}, {11'd16, 10'd10});
    c0 = de_cnt;
    frame(10, 0, 0, 0);
    check("de_per_frame", de_cnt - c0, 32);
    check("first_de", {first_r.data, first_r.x, first_r.y}, {16'h0204, 9'd0, 9'd0});
    consec = 0;
    c0 = de_cnt;
    repeat (2) frame(10, 0, 1, 0);
    check("de_alt", de_cnt - c0, 64);
    check("de_consec", consec, 0);
    check("lock_alt", b.locked_o, 1);
    repeat (2) frame(11, 0, 0, 0);
    check("vchg_drop", b.locked_o, 0);
    repeat (4) frame(11, 0, 0, 0);
    check("vchg_relock6", b.locked_o, 0);
    frame(11, 0, 0, 0);
    check("vchg_relock7", {b.locked_o, b.v_total_o}, {1'b1, 10'd11});
    repeat (2100) samp(1'b1, 1'b1, 16'h55aa, 0);
    check("sat_lock", b.locked_o, 0);
    check("sat_htot", b.h_total_o, 16);
    do_reset();
    frame(10, 8, 0, 0);
    check("fid_a", b.FID_o, 1);
    frame(10, 0, 0, 0);
    check("fid_b", b.FID_o, 0);
    frame(10, 8, 0, 0);
    check("fid_c", b.FID_o, 1);
    frame(10, 0, 0, 0);
    check("fid_d", b.FID_o, 0);
    repeat (8) frame(10, 0, 0, 0);
    check("lock_pre_rst", b.locked_o, 1);
    frame(10, 0, 0, 1);
    c0 = de_cnt;
    repeat (6) frame(10, 0, 0, 0);
    check("rst_lock6", b.locked_o, 0);
    check("rst_no_de", de_cnt - c0, 0);
    frame(10, 0, 0, 0);
    check("rst_lock7", b.locked_o, 1);
    check("de_unlocked", de_unlk, 0);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
